// File: rtl/window_min_max_tracker_if.sv
// Stream interface for window_min_max_tracker: sample input, result output and flush.
// The master drives samples and consumes results; the slave is the tracker itself.
interface window_min_max_tracker_if #(
  parameter int unsigned N   = 32,
  parameter int unsigned WIN = 8
);
  localparam int unsigned IW = (WIN > 1) ? $clog2(WIN) : 1;

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_min;
  logic [N-1:0]  out_max;
  logic [IW-1:0] out_min_idx;
  logic [IW-1:0] out_max_idx;
  logic          out_all_eq;

  modport master (
    output flush,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_min,
    input  out_max,
    input  out_min_idx,
    input  out_max_idx,
    input  out_all_eq
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_min,
    output out_max,
    output out_min_idx,
    output out_max_idx,
    output out_all_eq
  );
endinterface

// File: rtl/window_min_max_tracker.sv
// Tracks unsigned min/max (with first-occurrence index) over windows of WIN accepted samples
// and presents one registered result beat per window on a valid/ready output.
module window_min_max_tracker #(
  parameter int unsigned N   = 32,
  parameter int unsigned WIN = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  window_min_max_tracker_if.slave   bus
);

  localparam int unsigned IW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned CW = IW + 1;
  localparam logic [CW-1:0] LastCnt = CW'(WIN - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  min_q, min_d;
  logic [N-1:0]  max_q, max_d;
  logic [IW-1:0] min_idx_q, min_idx_d;
  logic [IW-1:0] max_idx_q, max_idx_d;

  logic [N-1:0]  out_min_q, out_min_d;
  logic [N-1:0]  out_max_q, out_max_d;
  logic [IW-1:0] out_min_idx_q, out_min_idx_d;
  logic [IW-1:0] out_max_idx_q, out_max_idx_d;
  logic          out_all_eq_q, out_all_eq_d;

  logic in_ready;
  logic accept;
  logic win_done;

  assign in_ready = !rst && (state_q != StHold);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    min_d         = min_q;
    max_d         = max_q;
    min_idx_d     = min_idx_q;
    max_idx_d     = max_idx_q;
    out_min_d     = out_min_q;
    out_max_d     = out_max_q;
    out_min_idx_d = out_min_idx_q;
    out_max_idx_d = out_max_idx_q;
    out_all_eq_d  = out_all_eq_q;
    win_done      = 1'b0;

    // flush wins over any sample or result transfer offered in the same cycle
    if (bus.flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            min_d     = bus.in_data;
            max_d     = bus.in_data;
            min_idx_d = '0;
            max_idx_d = '0;
            cnt_d     = CW'(1);
            if (WIN == 1) begin
              win_done = 1'b1;
            end else begin
              state_d = StAccum;
            end
          end
        end
        StAccum: begin
          if (accept) begin
            // strict compares: ties keep the earlier index
            if (bus.in_data < min_q) begin
              min_d     = bus.in_data;
              min_idx_d = cnt_q[IW-1:0];
            end
            if (bus.in_data > max_q) begin
              max_d     = bus.in_data;
              max_idx_d = cnt_q[IW-1:0];
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LastCnt) begin
              win_done = 1'b1;
            end
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    // Result registers only load on entry to HOLD so they stay stable until taken
    if (win_done) begin
      state_d       = StHold;
      out_min_d     = min_d;
      out_max_d     = max_d;
      out_min_idx_d = min_idx_d;
      out_max_idx_d = max_idx_d;
      out_all_eq_d  = (min_d == max_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      min_q         <= '0;
      max_q         <= '0;
      min_idx_q     <= '0;
      max_idx_q     <= '0;
      out_min_q     <= '0;
      out_max_q     <= '0;
      out_min_idx_q <= '0;
      out_max_idx_q <= '0;
      out_all_eq_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      min_q         <= min_d;
      max_q         <= max_d;
      min_idx_q     <= min_idx_d;
      max_idx_q     <= max_idx_d;
      out_min_q     <= out_min_d;
      out_max_q     <= out_max_d;
      out_min_idx_q <= out_min_idx_d;
      out_max_idx_q <= out_max_idx_d;
      out_all_eq_q  <= out_all_eq_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (state_q == StHold);
  assign bus.out_min     = out_min_q;
  assign bus.out_max     = out_max_q;
  assign bus.out_min_idx = out_min_idx_q;
  assign bus.out_max_idx = out_max_idx_q;
  assign bus.out_all_eq  = out_all_eq_q;

endmodule
